// File: rtl/fc_irq_ctrl.sv
// fc_irq_ctrl: fabric-controller interrupt controller.
// Edge-detects NB_IRQ level lines into a pending register. One line
// (FIFO_IRQ_ID) is driven by a small event FIFO. The pending lines are
// arbitrated with fixed priority (highest index wins) and presented to the
// core as a registered request/id pair. The core acknowledges by id.
module fc_irq_ctrl #(
    parameter int NB_IRQ         = 32,
    parameter int EVENT_ID_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_IRQ_ID    = 26,
    localparam int IDW           = (NB_IRQ > 1) ? $clog2(NB_IRQ) : 1,
    localparam int CNTW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [NB_IRQ-1:0]         irqs_i,
    input  logic [NB_IRQ-1:0]         mask_i,

    input  logic                      evt_valid_i,
    input  logic [EVENT_ID_WIDTH-1:0] evt_data_i,
    output logic                      evt_fulln_o,

    input  logic                      evt_pop_i,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    output logic [CNTW-1:0]           evt_count_o,

    output logic                      core_irq_req_o,
    output logic [IDW-1:0]            core_irq_id_o,
    output logic [NB_IRQ-1:0]         core_irq_x_o,

    input  logic                      core_irq_ack_i,
    input  logic [IDW-1:0]            core_irq_ack_id_i,

    output logic [NB_IRQ-1:0]         pending_o
);

    localparam int PTRW = $clog2(FIFO_DEPTH);

    localparam logic [CNTW-1:0]   FULL_CNT   = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0]   ZERO_CNT   = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]   ONE_CNT    = CNTW'(1'b1);
    localparam logic [PTRW-1:0]   ONE_PTR    = PTRW'(1'b1);
    localparam logic [NB_IRQ-1:0] ZERO_VEC   = {NB_IRQ{1'b0}};
    localparam logic [NB_IRQ-1:0] FIFO_BIT   = {{(NB_IRQ-1){1'b0}}, 1'b1} << FIFO_IRQ_ID;
    localparam logic [IDW:0]      NB_IRQ_LIM = (IDW+1)'(NB_IRQ);
    localparam logic [IDW-1:0]    FIFO_ID    = IDW'(FIFO_IRQ_ID);

    // One-hot decode of a line index.
    function automatic logic [NB_IRQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        id_to_onehot = {{(NB_IRQ-1){1'b0}}, 1'b1} << id;
    endfunction

    // Fixed-priority search: returns {found, index}, highest set index wins.
    function automatic logic [IDW:0] find_highest(input logic [NB_IRQ-1:0] vec);
        logic [IDW:0] res;
        res = {(IDW+1){1'b0}};
        for (int i = 0; i < NB_IRQ; i++) begin
            if (vec[i]) begin
                res = {1'b1, IDW'(i)};
            end else begin
                res = res;
            end
        end
        find_highest = res;
    endfunction

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EVENT_ID_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTRW-1:0]           wr_ptr_r;
    logic [PTRW-1:0]           rd_ptr_r;
    logic [CNTW-1:0]           count_r;
    logic                      push_s;
    logic                      pop_s;

    // A push while full is dropped; a pop while empty is ignored. This also
    // gives the full/empty simultaneous push+pop behaviour for free.
    assign push_s = evt_valid_i && (count_r != FULL_CNT);
    assign pop_s  = evt_pop_i && (count_r != ZERO_CNT);

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= evt_data_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    assign evt_fulln_o = (count_r != FULL_CNT);
    assign evt_count_o = count_r;
    assign evt_data_o  = (count_r != ZERO_CNT) ? mem_r[rd_ptr_r] : {EVENT_ID_WIDTH{1'b0}};

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // armed_r[i] is set once line i has been seen low, so a line held high
    // across reset cannot produce a spurious edge when reset is released.
    logic [NB_IRQ-1:0] irq_prev_r;
    logic [NB_IRQ-1:0] armed_r;
    logic [NB_IRQ-1:0] rise_s;

    // Previous-value history and arming qualifier for the edge detector.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_prev_r <= ZERO_VEC;
            armed_r    <= ~irqs_i;
        end else begin
            irq_prev_r <= irqs_i;
            armed_r    <= armed_r | ~irqs_i;
        end
    end

    // The FIFO line is owned by the event FIFO, so its input bit is ignored.
    assign rise_s = irqs_i & ~irq_prev_r & armed_r & ~FIFO_BIT;

    // ------------------------------------------------------------------
    // Acknowledge decode and pending register
    // ------------------------------------------------------------------
    logic              ack_in_range_s;
    logic [NB_IRQ-1:0] ack_clr_s;
    logic [NB_IRQ-1:0] pending_r;
    logic [NB_IRQ-1:0] pending_next_s;

    assign ack_in_range_s = core_irq_ack_i && ({1'b0, core_irq_ack_id_i} < NB_IRQ_LIM);

    // Acks on the FIFO line do not clear anything: only draining the FIFO does.
    always_comb begin
        ack_clr_s = ZERO_VEC;
        if (ack_in_range_s && (core_irq_ack_id_i != FIFO_ID)) begin
            ack_clr_s = id_to_onehot(core_irq_ack_id_i);
        end else begin
            ack_clr_s = ZERO_VEC;
        end
    end

    // Next pending value: a new edge wins over a same-cycle ack on that line.
    always_comb begin
        pending_next_s = ((pending_r & ~ack_clr_s) | rise_s) & ~FIFO_BIT;
        if (count_r != ZERO_CNT) begin
            pending_next_s = pending_next_s | FIFO_BIT;
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Pending register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r <= ZERO_VEC;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign pending_o = pending_r;

    // ------------------------------------------------------------------
    // Arbitration and core request
    // ------------------------------------------------------------------
    logic [IDW:0]      arb_s;
    logic              arb_valid_s;
    logic [IDW-1:0]    arb_id_s;
    logic              req_r;
    logic [IDW-1:0]    id_r;
    logic [NB_IRQ-1:0] x_r;

    assign arb_s       = find_highest(pending_r & mask_i);
    assign arb_valid_s = arb_s[IDW];
    assign arb_id_s    = arb_s[IDW-1:0];

    // Request is re-evaluated every cycle so a higher line can pre-empt an
    // unacked one; an accepted ack forces a one-cycle bubble while the
    // pending register absorbs the clear. The id holds while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_r <= 1'b0;
            id_r  <= {IDW{1'b0}};
            x_r   <= ZERO_VEC;
        end else if (ack_in_range_s) begin
            req_r <= 1'b0;
            id_r  <= id_r;
            x_r   <= ZERO_VEC;
        end else if (arb_valid_s) begin
            req_r <= 1'b1;
            id_r  <= arb_id_s;
            x_r   <= id_to_onehot(arb_id_s);
        end else begin
            req_r <= 1'b0;
            id_r  <= id_r;
            x_r   <= ZERO_VEC;
        end
    end

    assign core_irq_req_o = req_r;
    assign core_irq_id_o  = id_r;
    assign core_irq_x_o   = x_r;

endmodule
